// File: rtl/tms320c1x_seq_if.sv
// Decoder and program-memory bus of the TMS320C1x program sequencer.
// The master side is the sequencer; the slave side is the decoder/parent.
interface tms320c1x_seq_if #(
   parameter int PC_W = 12
);
   logic            CE;
   logic [15:0]     PROM_D;
   logic [PC_W-1:0] PA;
   logic [15:0]     IR;
   logic [1:0]      STATE;
   logic [15:0]     IMM;
   logic [1:0]      PCU;
   logic            PUSH;
   logic            POP;
   logic            IWR;
   logic            LST;
   logic            COND;
   logic [PC_W-1:0] DIN;
   logic            PUSH_SEL;
   logic [PC_W-1:0] PUSH_DATA;
   logic [PC_W-1:0] NPC;
   logic [PC_W-1:0] TOS;
   logic            INT_REQ;
   logic            INTM;
   logic            IACK;

   modport master (
      input  CE, PROM_D, PCU, PUSH, POP, IWR, LST, COND, DIN,
             PUSH_SEL, PUSH_DATA, INT_REQ, INTM,
      output PA, IR, STATE, IMM, NPC, TOS, IACK
   );

   modport slave (
      output CE, PROM_D, PCU, PUSH, POP, IWR, LST, COND, DIN,
             PUSH_SEL, PUSH_DATA, INT_REQ, INTM,
      input  PA, IR, STATE, IMM, NPC, TOS, IACK
   );
endinterface

// File: rtl/tms320c1x_seq.sv
// TMS320C1x program sequencer: PC, instruction register, decoder sub-state,
// second-word capture, hardware return stack and interrupt entry.
module tms320c1x_seq #(
   parameter int              PC_W    = 12,
   parameter int              STK_D   = 4,
   parameter logic [PC_W-1:0] INT_VEC = 12'h002
) (
   input  logic            CLK,
   input  logic            RST,
   tms320c1x_seq_if.master bus
);

   localparam logic [15:0]     NOP_OP = 16'h7F80;
   localparam logic [15:0]     ISR_OP = 16'hF000;
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   typedef enum logic {FETCH, EXEC} phase_t;

   phase_t          phase;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;
   logic [15:0]     imm;
   logic [1:0]      state;
   logic            iack;
   logic [PC_W-1:0] stk [STK_D];

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] npc;
   logic [PC_W-1:0] push_val;
   logic            take_int;

   // Return address is taken from the pre-edge PC, skipping an operand word.
   assign pc_inc   = pc + PC_ONE;
   assign npc      = bus.IWR ? pc_inc : pc;
   assign push_val = bus.PUSH_SEL ? bus.PUSH_DATA : npc;
   assign take_int = bus.INT_REQ && !bus.INTM;

   assign bus.PA    = pc;
   assign bus.IR    = ir;
   assign bus.STATE = state;
   assign bus.IMM   = imm;
   assign bus.NPC   = npc;
   assign bus.TOS   = stk[0];
   assign bus.IACK  = iack;

   // FETCH/EXEC phase machine owning PC, IR, STATE, IMM and IACK.
   // NOTE: every register here is assigned with <= so all updates use pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         phase <= FETCH;
         pc    <= '0;
         ir    <= NOP_OP;
         state <= 2'd0;
         imm   <= '0;
         iack  <= 1'b0;
      end else if (bus.CE) begin
         iack <= 1'b0;
         case (phase)
            FETCH: begin
               state <= 2'd0;
               phase <= EXEC;
               if (take_int) begin
                  // ISR pseudo-op; PC stays put so it is the pushed return address.
                  ir   <= ISR_OP;
                  iack <= 1'b1;
               end else begin
                  ir <= bus.PROM_D;
                  pc <= pc_inc;
               end
            end
            EXEC: begin
               if (bus.IWR) imm <= bus.PROM_D;
               case (bus.PCU)
                  2'b00: pc <= npc;
                  2'b01: pc <= bus.DIN;
                  2'b10: pc <= bus.COND ? bus.PROM_D[PC_W-1:0] : pc_inc;
                  2'b11: pc <= INT_VEC;
               endcase
               if (bus.LST) begin
                  state <= 2'd0;
                  phase <= FETCH;
               end else if (state != 2'd3) begin
                  state <= state + 2'd1;
               end
            end
         endcase
      end
   end

   // Hardware stack: push shifts down and drops the bottom, pop shifts up and keeps it.
   // NOTE: the stack array is reset explicitly because its contents are architecturally visible.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < STK_D; i++) stk[i] <= '0;
      end else if (bus.CE) begin
         if (bus.PUSH && bus.POP) begin
            stk[0] <= push_val;
         end else if (bus.PUSH) begin
            for (int i = STK_D - 1; i > 0; i--) stk[i] <= stk[i-1];
            stk[0] <= push_val;
         end else if (bus.POP) begin
            for (int i = 0; i < STK_D - 1; i++) stk[i] <= stk[i+1];
         end
      end
   end

endmodule

// File: tb/tb_tms320c1x_seq.sv
// Self-checking bench for tms320c1x_seq: the bench plays the decoder and the
// program ROM, a behavioural model tracks the expected outputs every cycle,
// and directed steps pin hand-computed values.
module tb_tms320c1x_seq;
   localparam int PC_W = 12;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   tms320c1x_seq_if #(.PC_W(PC_W)) bus ();

   tms320c1x_seq #(.PC_W(PC_W), .STK_D(4), .INT_VEC(12'h002)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   always #5 CLK = ~CLK;

   logic [15:0] prom [4096];
   assign bus.PROM_D = prom[bus.PA];

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;
   int iack_seen = 0;

   // Behavioural model state
   int m_pc, m_ir, m_st, m_imm, m_iack;
   bit m_exec;
   int m_stk[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Advance the model by one clock edge using the inputs that are stable now.
   task automatic model_step();
      int pd, npc, v;
      if (RST) begin
         m_pc = 0; m_ir = 16'h7F80; m_st = 0; m_imm = 0; m_iack = 0; m_exec = 1'b0;
         m_stk = '{0, 0, 0, 0};
      end else if (bus.CE) begin
         pd  = int'(prom[m_pc]);
         npc = bus.IWR ? (m_pc + 1) % 4096 : m_pc;
         v   = bus.PUSH_SEL ? int'(bus.PUSH_DATA) : npc;
         if (!m_exec) begin
            if (bus.INT_REQ && !bus.INTM) begin
               m_ir = 16'hF000; m_iack = 1;
            end else begin
               m_ir = pd; m_pc = (m_pc + 1) % 4096; m_iack = 0;
            end
            m_st = 0; m_exec = 1'b1;
         end else begin
            m_iack = 0;
            if (bus.IWR) m_imm = pd;
            case (bus.PCU)
               2'd0: m_pc = npc;
               2'd1: m_pc = int'(bus.DIN);
               2'd2: m_pc = bus.COND ? pd % 4096 : (m_pc + 1) % 4096;
               2'd3: m_pc = 2;
            endcase
            if (bus.LST) begin m_exec = 1'b0; m_st = 0; end
            else if (m_st < 3) m_st = m_st + 1;
         end
         if (bus.PUSH && bus.POP) m_stk[0] = v;
         else if (bus.PUSH) begin m_stk.push_front(v); void'(m_stk.pop_back()); end
         else if (bus.POP) begin m_stk.push_back(m_stk[$]); void'(m_stk.pop_front()); end
      end
   endtask

   // Compare DUT against the model on the falling edge, then step the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("cyc_pa",    bus.PA,    m_pc);
         check("cyc_ir",    bus.IR,    m_ir);
         check("cyc_state", bus.STATE, m_st);
         check("cyc_imm",   bus.IMM,   m_imm);
         check("cyc_tos",   bus.TOS,   m_stk[0]);
         check("cyc_npc",   bus.NPC,   bus.IWR ? (m_pc + 1) % 4096 : m_pc);
         check("cyc_iack",  bus.IACK,  m_iack);
         if (bus.IACK === 1'b1) iack_seen++;
      end
      model_step();
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] pcu, input logic push, input logic pop,
                        input logic iwr, input logic lst, input logic cond,
                        input logic psel, input logic [11:0] din, input logic [11:0] pdata);
      bus.PCU = pcu; bus.PUSH = push; bus.POP = pop; bus.IWR = iwr; bus.LST = lst;
      bus.COND = cond; bus.PUSH_SEL = psel; bus.DIN = din; bus.PUSH_DATA = pdata;
      tick();
   endtask

   task automatic fetch();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000);
   endtask

   task automatic nop();
      drive(2'b00, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000);
   endtask

   task automatic jump(input logic [11:0] addr);
      fetch();
      drive(2'b01, 0, 0, 0, 1, 0, 0, addr, 12'h000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pops_exp[5];
      int st_exp[4];
      int iack_base;
      pops_exp = '{5, 4, 3, 2, 2};
      st_exp   = '{1, 2, 3, 3};

      for (int a = 0; a < 4096; a++) prom[a] = 16'h7F80;
      prom[12'h00A] = 16'hF900;  prom[12'h00B] = 16'h0123;
      prom[12'h020] = 16'hF800;  prom[12'h021] = 16'h0300;
      prom[12'h300] = 16'h7F8D;

      bus.CE = 1'b0; bus.INT_REQ = 1'b0; bus.INTM = 1'b0;
      bus.PCU = 2'b00; bus.PUSH = 1'b0; bus.POP = 1'b0; bus.IWR = 1'b0; bus.LST = 1'b0;
      bus.COND = 1'b0; bus.PUSH_SEL = 1'b0; bus.DIN = '0; bus.PUSH_DATA = '0;

      // Reset with CE low: reset must not depend on CE
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      chk_en = 1'b1;
      check("rst_pa",    bus.PA,    12'h000);
      check("rst_ir",    bus.IR,    16'h7F80);
      check("rst_state", bus.STATE, 2'd0);
      check("rst_imm",   bus.IMM,   16'h0000);
      check("rst_tos",   bus.TOS,   12'h000);
      check("rst_iack",  bus.IACK,  1'b0);
      bus.CE = 1'b1;

      // NOP stream: one address per two CE cycles
      for (int k = 1; k <= 4; k++) begin
         fetch();
         check("nop_ir", bus.IR, 16'h7F80);
         check("nop_state", bus.STATE, 2'd0);
         nop();
         check("nop_pa", bus.PA, k);
      end

      // CE low for 3 cycles mid-EXEC with disruptive decoder fields
      fetch();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000);
      bus.CE = 1'b0;
      repeat (3) drive(2'b11, 1, 1, 1, 1, 1, 1, 12'hABC, 12'hDEF);
      check("stall_state", bus.STATE, 2'd1);
      check("stall_pa", bus.PA, 12'h005);
      check("stall_tos", bus.TOS, 12'h000);
      bus.CE = 1'b1;
      nop();
      check("stall_done_pa", bus.PA, 12'h005);

      // STATE saturates at 3
      fetch();
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000);
         check("state_sat", bus.STATE, st_exp[k]);
      end
      nop();

      // Branch taken and not taken at PC=10
      jump(12'h00A);
      fetch();
      check("b_ir", bus.IR, 16'hF900);
      drive(2'b10, 0, 0, 1, 1, 1, 0, 12'h000, 12'h000);
      check("b_taken_imm", bus.IMM, 16'h0123);
      check("b_taken_pa", bus.PA, 12'h123);
      jump(12'h00A);
      fetch();
      drive(2'b10, 0, 0, 1, 1, 0, 0, 12'h000, 12'h000);
      check("b_not_taken_pa", bus.PA, 12'h00C);

      // CALL 0x300 from 0x20, then RET
      jump(12'h020);
      fetch();
      drive(2'b10, 1, 0, 1, 1, 1, 0, 12'h000, 12'h000);
      check("call_tos", bus.TOS, 12'h022);
      check("call_pa", bus.PA, 12'h300);
      fetch();
      drive(2'b01, 0, 1, 0, 1, 0, 0, 12'h022, 12'h000);
      check("ret_pa", bus.PA, 12'h022);
      check("ret_tos", bus.TOS, 12'h000);

      // Five pushes overflow the 4-deep stack, five pops duplicate the bottom
      for (int k = 1; k <= 5; k++) begin
         fetch();
         drive(2'b00, 1, 0, 0, 1, 0, 1, 12'h000, 12'(k));
         check("push_tos", bus.TOS, k);
      end
      for (int k = 0; k < 5; k++) begin
         check("pop_tos", bus.TOS, pops_exp[k]);
         fetch();
         drive(2'b00, 0, 1, 0, 1, 0, 0, 12'h000, 12'h000);
      end
      check("pop_final_tos", bus.TOS, 12'h002);
      fetch();
      drive(2'b00, 1, 1, 0, 1, 0, 1, 12'h000, 12'h7AB);
      check("pushpop_tos", bus.TOS, 12'h7AB);

      // PC wraps from 4095 to 0
      jump(12'hFFF);
      fetch();
      check("wrap_pa", bus.PA, 12'h000);
      nop();

      // Interrupt taken at PC=0x40
      jump(12'h040);
      iack_base = iack_seen;
      bus.INT_REQ = 1'b1; bus.INTM = 1'b0;
      fetch();
      check("int_ir", bus.IR, 16'hF000);
      check("int_iack", bus.IACK, 1'b1);
      check("int_pa", bus.PA, 12'h040);
      drive(2'b00, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000);
      check("isr_iack_low", bus.IACK, 1'b0);
      check("isr_tos", bus.TOS, 12'h040);
      drive(2'b11, 0, 0, 0, 1, 0, 0, 12'h000, 12'h000);
      check("isr_pa", bus.PA, 12'h002);
      bus.INT_REQ = 1'b0;
      check("iack_pulses", iack_seen - iack_base, 1);

      // Same request, masked
      jump(12'h040);
      bus.INT_REQ = 1'b1; bus.INTM = 1'b1;
      fetch();
      check("masked_ir", bus.IR, 16'h7F80);
      check("masked_iack", bus.IACK, 1'b0);
      check("masked_pa", bus.PA, 12'h041);
      nop();
      bus.INT_REQ = 1'b0; bus.INTM = 1'b0;

      // Reset mid-instruction abandons it
      fetch();
      drive(2'b00, 1, 0, 0, 0, 0, 1, 12'h000, 12'h555);
      RST = 1'b1;
      drive(2'b11, 1, 0, 1, 0, 1, 1, 12'h321, 12'h777);
      RST = 1'b0;
      bus.PCU = 2'b00; bus.PUSH = 1'b0; bus.IWR = 1'b0; bus.COND = 1'b0; bus.PUSH_SEL = 1'b0;
      check("mid_rst_pa", bus.PA, 12'h000);
      check("mid_rst_ir", bus.IR, 16'h7F80);
      check("mid_rst_state", bus.STATE, 2'd0);
      check("mid_rst_tos", bus.TOS, 12'h000);
      check("mid_rst_imm", bus.IMM, 16'h0000);
      fetch();
      nop();
      check("post_rst_pa", bus.PA, 12'h001);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
